// File: rtl/univ_shift_reg_pkg.sv
// Mode encodings and shift-op classification shared by the register, its counter and the bench.
package univ_shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  // Shift ops advance the word counter; LOAD and CLR restart it.
  function automatic logic is_shift_op(input logic [2:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

  function automatic logic is_restart_op(input logic [2:0] m);
    return (m == MODE_LOAD) || (m == MODE_CLR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift_counter.sv
// Counts shift ops modulo WIDTH; done is a registered pulse the cycle after the WIDTH-th shift.
module shift_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic syncReset_n,
  input  logic en,
  input  logic inc,
  input  logic clr,
  output logic done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (en) begin
      if (clr) begin
        count_d = '0;
      end else if (inc) begin
        if (count_q == LAST) begin
          count_d = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!syncReset_n) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold/shift/rotate/ASR/load/clear) with word-boundary pulse.
module univ_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             syncReset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             serInMsb,
  input  logic             serInLsb,
  output logic [WIDTH-1:0] Q,
  output logic             serOutMsb,
  output logic             serOutLsb,
  output logic             shiftDone
);

  import univ_shift_reg_pkg::*;

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = {serInMsb, q_q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], serInLsb};
      MODE_LOAD: q_d = D;
      MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
      MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      MODE_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
      MODE_CLR:  q_d = '0;  // clears to zero, not RESET_VAL
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!syncReset_n) begin
      q_q <= RESET_VAL;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  shift_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk         (clk),
    .syncReset_n (syncReset_n),
    .en          (en),
    .inc         (is_shift_op(mode)),
    .clr         (is_restart_op(mode)),
    .done        (shiftDone)
  );

  assign Q         = q_q;
  assign serOutMsb = q_q[WIDTH-1];
  assign serOutLsb = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench: vector table plus hand-written multi-cycle sequences, scoreboard-checked.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, smsb, slsb;
  logic [2:0] mode;
  logic [7:0] D;
  logic [7:0] q8;
  logic       msb8, lsb8, done8;
  logic [3:0] q4;
  logic       msb4, lsb4, done4;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .syncReset_n(rst_n), .en(en), .mode(mode), .D(D),
    .serInMsb(smsb), .serInLsb(slsb), .Q(q8), .serOutMsb(msb8),
    .serOutLsb(lsb8), .shiftDone(done8)
  );

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'hF)) dut4 (
    .clk(clk), .syncReset_n(rst_n), .en(en), .mode(mode), .D(D[3:0]),
    .serInMsb(smsb), .serInLsb(slsb), .Q(q4), .serOutMsb(msb4),
    .serOutLsb(lsb4), .shiftDone(done4)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       done;
    logic       chk4;
    logic [3:0] q4;
    logic       done4;
  } exp_t;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       smsb;
    logic       slsb;
    logic [7:0] exp_q;
    logic       exp_done;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   step   = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, expv);
    end
  endtask

  function automatic exp_t ex(input logic [7:0] q, input logic d,
                              input logic c4 = 1'b0, input logic [3:0] qq4 = 4'h0,
                              input logic d4 = 1'b0);
    exp_t x;
    x.q = q; x.done = d; x.chk4 = c4; x.q4 = qq4; x.done4 = d4;
    return x;
  endfunction

  // Drive one cycle's inputs, queue the expectation, sample 1ns after the edge.
  task automatic cycle(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] d, input logic sm, input logic sl, input exp_t x);
    exp_t got;
    rst_n = r; en = e; mode = m; D = d; smsb = sm; slsb = sl;
    sb.push_back(x);
    @(posedge clk);
    #1;
    step++;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      got = sb.pop_front();
      chk("q8", q8, got.q);
      chk("done8", 8'(done8), 8'(got.done));
      chk("msb8", 8'(msb8), 8'(got.q[7]));
      chk("lsb8", 8'(lsb8), 8'(got.q[0]));
      if (got.chk4) begin
        chk("q4", 8'(q4), 8'(got.q4));
        chk("done4", 8'(done4), 8'(got.done4));
        chk("msb4", 8'(msb4), 8'(got.q4[3]));
        chk("lsb4", 8'(lsb4), 8'(got.q4[0]));
      end
    end
  endtask

  vec_t       vecs[12];
  logic [7:0] rol_exp[6] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60};
  logic [7:0] e;

  initial begin
    vecs[0]  = '{1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[1]  = '{1'b1, MODE_SHL,  8'h00, 1'b0, 1'b1, 8'h4B, 1'b0};
    vecs[2]  = '{1'b1, MODE_LOAD, 8'h80, 1'b0, 1'b0, 8'h80, 1'b0};
    vecs[3]  = '{1'b1, MODE_ASR,  8'h00, 1'b0, 1'b0, 8'hC0, 1'b0};
    vecs[4]  = '{1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0};
    vecs[5]  = '{1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0, 8'hC0, 1'b0};
    vecs[6]  = '{1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0};
    vecs[7]  = '{1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h03, 1'b0};
    vecs[8]  = '{1'b1, MODE_SHR,  8'h00, 1'b1, 1'b0, 8'h81, 1'b0};
    vecs[9]  = '{1'b1, MODE_HOLD, 8'hFF, 1'b0, 1'b0, 8'h81, 1'b0};
    vecs[10] = '{1'b0, MODE_CLR,  8'hFF, 1'b0, 1'b0, 8'h81, 1'b0};
    vecs[11] = '{1'b1, MODE_CLR,  8'hFF, 1'b0, 1'b0, 8'h00, 1'b0};

    rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD; D = 8'h00; smsb = 1'b0; slsb = 1'b0;

    // Reset state, then a reset asserted between edges must not act early and beats LOAD.
    cycle(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, ex(8'h00, 1'b0, 1'b1, 4'hF, 1'b0));
    cycle(1'b1, 1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, ex(8'hA5, 1'b0));
    rst_n = 1'b0; en = 1'b1; mode = MODE_LOAD; D = 8'h3C;
    #2;
    chk("q_before_edge", q8, 8'hA5);
    cycle(1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, ex(8'h00, 1'b0, 1'b1, 4'hF, 1'b0));

    foreach (vecs[i])
      cycle(1'b1, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].smsb, vecs[i].slsb,
            ex(vecs[i].exp_q, vecs[i].exp_done));

    // Word count: one pulse after the 8th SHR, another after 8 more.
    cycle(1'b1, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, ex(8'h81, 1'b0));
    for (int k = 1; k <= 16; k++) begin
      e = (k <= 8) ? (8'h81 >> k) : 8'h00;
      cycle(1'b1, 1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, ex(e, (k == 8) || (k == 16)));
    end
    cycle(1'b1, 1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, ex(8'h00, 1'b0));

    // Stall with en=0 mid-word, then finish the word.
    cycle(1'b1, 1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0, ex(8'h01, 1'b0));
    for (int k = 1; k <= 5; k++)
      cycle(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, ex(8'h01 << k, 1'b0));
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 1'b0, MODE_LOAD, 8'hFF, 1'b0, 1'b0, ex(8'h20, 1'b0));
    cycle(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, ex(8'h40, 1'b0));
    cycle(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, ex(8'h80, 1'b0));
    cycle(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, ex(8'h00, 1'b1));

    // LOAD mid-word restarts the count: a full 8 shifts are needed again.
    cycle(1'b1, 1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0, ex(8'h01, 1'b0));
    for (int k = 1; k <= 5; k++)
      cycle(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, ex(8'h01 << k, 1'b0));
    cycle(1'b1, 1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0, ex(8'h01, 1'b0));
    for (int k = 1; k <= 8; k++)
      cycle(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, ex(8'h01 << k, k == 8));

    // Reset mid-word, checked on both the 8-bit and the 4-bit (RESET_VAL=F) instance.
    cycle(1'b1, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, ex(8'h81, 1'b0, 1'b1, 4'h1, 1'b0));
    for (int k = 0; k < 6; k++)
      cycle(1'b1, 1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0, ex(rol_exp[k], 1'b0));
    cycle(1'b0, 1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0, ex(8'h00, 1'b0, 1'b1, 4'hF, 1'b0));
    for (int k = 1; k <= 8; k++)
      cycle(1'b1, 1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0,
            ex(8'h00, k == 8, 1'b1, 4'hF, (k == 4) || (k == 8)));
    cycle(1'b1, 1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, ex(8'h00, 1'b0, 1'b1, 4'hF, 1'b0));

    if (sb.size() != 0) chk("scoreboard_leftover", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
